// File: rtl/pipe_credit_receiver_if.sv
// Handshake bundle between a valid-only pipeline, its credit source and a
// ready/valid consumer, as seen by the credit receiver (slave) and its environment (master).
interface pipe_credit_receiver_if #(
   parameter int width = 8,
   parameter int depth = 8
);
   logic                         issue_vld;
   logic                         issue_rdy;
   logic                         pipe_vld;
   logic [width-1:0]             pipe_data;
   logic                         out_vld;
   logic                         out_rdy;
   logic [width-1:0]             out_data;
   logic [$clog2(depth+1)-1:0]   credits;
   logic                         overflow_err;

   modport master (
      output issue_vld, pipe_vld, pipe_data, out_rdy,
      input  issue_rdy, out_vld, out_data, credits, overflow_err
   );

   modport slave (
      input  issue_vld, pipe_vld, pipe_data, out_rdy,
      output issue_rdy, out_vld, out_data, credits, overflow_err
   );
endinterface

// File: rtl/pipe_credit_receiver.sv
// Credit-controlled show-ahead FIFO that turns a non-stallable valid/data pipeline
// output into a ready/valid stream, handing out one credit per free FIFO entry.
module pipe_credit_receiver #(
   parameter int width = 8,
   parameter int depth = 8
) (
   input logic                  clk,
   input logic                  rst,
   pipe_credit_receiver_if.slave bus
);
   localparam int aw = $clog2(depth);
   localparam int cw = $clog2(depth + 1);
   localparam logic [cw-1:0] depth_c = cw'(depth);
   localparam logic [cw-1:0] one_c   = cw'(1);
   localparam logic [aw-1:0] step_c  = aw'(1);

   logic [width-1:0] mem [depth];
   logic [aw-1:0]    rd_ptr;
   logic [aw-1:0]    wr_ptr;
   logic [cw-1:0]    occupancy;
   logic [cw-1:0]    credits_q;
   logic             overflow_q;

   logic issue_rdy;
   logic out_vld;
   logic issue;
   logic pop;
   logic full;
   logic wr_en;

   assign issue_rdy = (credits_q != '0);
   assign out_vld   = (occupancy != '0);
   assign full      = (occupancy == depth_c);
   assign issue     = bus.issue_vld & issue_rdy;
   assign pop       = out_vld & bus.out_rdy;
   // A pop in the same cycle frees the slot the incoming word needs.
   assign wr_en     = bus.pipe_vld & (~full | pop);

   assign bus.issue_rdy    = issue_rdy;
   assign bus.out_vld      = out_vld;
   assign bus.out_data     = mem[rd_ptr];
   assign bus.credits      = credits_q;
   assign bus.overflow_err = overflow_q;

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values, regardless of statement order within the block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: storage is cleared on reset so out_data reads zero afterwards;
         // this keeps the memory in flops rather than a RAM macro.
         for (int i = 0; i < depth; i++) mem[i] <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         occupancy  <= '0;
         credits_q  <= depth_c;
         overflow_q <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= bus.pipe_data;
            wr_ptr      <= wr_ptr + step_c;
         end
         if (pop) rd_ptr <= rd_ptr + step_c;

         case ({wr_en, pop})
            2'b10:   occupancy <= occupancy + one_c;
            2'b01:   occupancy <= occupancy - one_c;
            default: occupancy <= occupancy;
         endcase

         case ({issue, pop})
            2'b10:   credits_q <= credits_q - one_c;
            2'b01:   credits_q <= credits_q + one_c;
            default: credits_q <= credits_q;
         endcase

         // Only reachable when upstream launches without a credit.
         if (bus.pipe_vld && full && !pop) overflow_q <= 1'b1;
      end
   end
endmodule

// File: doc/pipe_credit_receiver.md
# pipe_credit_receiver

Receiving end of a valid-only pipeline: a credit-controlled output FIFO that absorbs transfers emerging from a non-stallable valid/data pipeline (such as a shift register with valid or an arithmetic formula pipe). It converts them into a ready/valid stream for a downstream consumer that may apply backpressure. It issues credits to the pipeline's input side, so the pipeline never launches more transfers than the FIFO can hold, and no data is lost.

## Interface
Parameters:
- width, 8, data width of every transfer
- depth, 8, FIFO entries and total credits; power of two, ≥ 2

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- issue_vld  input  1  upstream launches a transfer into the pipeline this cycle
- issue_rdy  output  1  a credit is available, so launching is permitted
- pipe_vld  input  1  pipeline output transfer valid
- pipe_data  input  width  pipeline output data
- out_vld  output  1  FIFO head valid
- out_rdy  input  1  downstream accepts head
- out_data  output  width  FIFO head data
- credits  output  $clog2(depth+1)  credits currently available
- overflow_err  output  1  sticky protocol-violation flag

## Operation
- Credit counter:
  - Resets to depth.
  - issue = issue_vld & issue_rdy; pop = out_vld & out_rdy.
  - credits_next = credits − issue + pop; issue and pop in the same cycle leave it unchanged.
- issue_rdy = (credits != 0), combinational from the counter register.
- issue_vld while issue_rdy=0 is ignored; no credit is consumed.
- FIFO:
  - depth entries, binary read and write pointers of $clog2(depth) bits that wrap modulo depth.
  - Occupancy counter of $clog2(depth+1) bits.
  - Show-ahead: out_data = mem[rd_ptr]; out_vld = (occupancy != 0).
- Write:
  - On pipe_vld, when not full or when pop occurs in the same cycle, write pipe_data at wr_ptr and advance wr_ptr.
  - pipe_vld while full and no pop sets overflow_err, and the data is dropped. This is only reachable if upstream violates the credit rule.
- Read: pop advances rd_ptr.
- Simultaneous write and pop: occupancy unchanged; both pointers advance.
- No empty bypass: data written into an empty FIFO is not visible on out_data in the same cycle.
- Invariant: credits + occupancy + transfers in flight in the pipeline = depth.
- overflow_err clears only on rst.

## Timing
- Reset, asynchronous and immediate: credits=depth, issue_rdy=1, out_vld=0, out_data=0 (storage cleared), overflow_err=0, pointers=0.
- Reset mid-operation discards all stored and in-flight accounting. The pipeline is expected to be reset in the same cycle.
- pipe_vld at edge N: out_vld=1 and out_data valid after edge N, so it can be popped in cycle N+1. Write-to-read latency is 1 cycle.
- A pop at edge N makes the credit visible on issue_rdy after edge N. Credit return latency is 1 cycle.
- An issue at edge N decrements credits after edge N. At credits=1, issue_rdy drops the cycle after the issue.
- out_data holds stable while out_vld=1 and out_rdy=0.

## Test plan
- Reset and idle:
  - Stimulus: assert rst asynchronously mid-cycle.
  - Response: credits=8, issue_rdy=1, out_vld=0, out_data=0, overflow_err=0, with no clock edge needed.
- Single transfer:
  - Stimulus: issue once (credits→7), then pipe_vld with data 0xA5 three cycles later.
  - Response: the next cycle shows out_vld=1, out_data=0xA5; pop it and credits returns to 8 one cycle later.
- Fill with backpressure:
  - Stimulus: out_rdy=0; issue 8 times; return data 0x01..0x08.
  - Response: issue_rdy=0 after the 8th issue; a 9th issue_vld is ignored with credits held at 0.
  - Then raise out_rdy: response is 0x01..0x08 in order, one per cycle, and credits reach 8.
- Simultaneous issue and pop at credits=0:
  - Stimulus: issue while issue_rdy=0 in the same cycle as a pop.
  - Response: credits becomes 1 and issue_rdy=1 next cycle; the ignored issue is not counted.
- Wrap-around and streaming:
  - Stimulus: 20 transfers with continuous out_rdy=1 and issue_vld=1.
  - Response: data in order across pointer wrap; occupancy never exceeds 8; overflow_err=0.
- Protocol violation:
  - Stimulus: FIFO full, out_rdy=0, force pipe_vld with 0xFF.
  - Response: overflow_err=1 and stays set; out_data is unchanged; the contents still drain 0x01..0x08.
  - Then assert rst: overflow_err=0.
